// File: rtl/ghost_collision_monitor.sv
// ghost_collision_monitor
// Frame-synchronous Pac-Man / ghost collision checker. On an accepted frame_tick it
// snapshots all sprite positions, scans one ghost per clock and then reports in a
// single cycle. It owns the lives counter, the post-death grace window and game over.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   frame_tick          one-cycle start-of-frame strobe
//   game_restart        synchronous restart (highest priority)
//   pacman_x/y          Pac-Man position
//   ghost_x/y           packed ghost positions (ghost i at [i*11 +: 11] / [i*10 +: 10])
//   ghost_active        per-ghost participation mask
//   ghost_frightened    per-ghost edible mask
//   busy                scan in progress
//   pacman_hit          one-cycle pulse, lethal collision accepted
//   ghost_eaten         one-cycle pulse mask of eaten ghosts
//   lives               remaining lives
//   grace_active        invulnerability window running
//   game_over           lives exhausted
module ghost_collision_monitor #(
    parameter int unsigned NUM_GHOSTS   = 4,
    parameter int unsigned TILE_SHIFT   = 4,
    parameter int unsigned HIT_MODE     = 0,
    parameter int unsigned HIT_DIST     = 8,
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned GRACE_FRAMES = 60
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_tick,
    input  logic                   game_restart,
    input  logic [10:0]            pacman_x,
    input  logic [9:0]             pacman_y,
    input  logic [NUM_GHOSTS*11-1:0] ghost_x,
    input  logic [NUM_GHOSTS*10-1:0] ghost_y,
    input  logic [NUM_GHOSTS-1:0]  ghost_active,
    input  logic [NUM_GHOSTS-1:0]  ghost_frightened,
    output logic                   busy,
    output logic                   pacman_hit,
    output logic [NUM_GHOSTS-1:0]  ghost_eaten,
    output logic [3:0]             lives,
    output logic                   grace_active,
    output logic                   game_over
);

    localparam int unsigned IdxW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_GHOSTS - 1);

    typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

    state_e                    state_q;
    logic [IdxW-1:0]           idx_q;
    logic [10:0]               px_q;
    logic [9:0]                py_q;
    logic [NUM_GHOSTS*11-1:0]  gx_q;
    logic [NUM_GHOSTS*10-1:0]  gy_q;
    logic [NUM_GHOSTS-1:0]     act_q;
    logic [NUM_GHOSTS-1:0]     fright_q;
    logic                      lethal_q;
    logic [NUM_GHOSTS-1:0]     eaten_q;
    logic [7:0]                grace_q;

    // Snapshot of the ghost currently being compared
    logic [10:0]        gx_sel;
    logic [9:0]         gy_sel;
    logic               act_sel;
    logic               fright_sel;
    logic signed [11:0] dx;
    logic signed [10:0] dy;
    logic [11:0]        adx;
    logic [10:0]        ady;
    logic               tile_match;
    logic               box_match;
    logic               contact;

    always_comb begin
        gx_sel     = '0;
        gy_sel     = '0;
        act_sel    = 1'b0;
        fright_sel = 1'b0;
        for (int i = 0; i < int'(NUM_GHOSTS); i++) begin
            if (idx_q == IdxW'(i)) begin
                gx_sel     = gx_q[i*11 +: 11];
                gy_sel     = gy_q[i*10 +: 10];
                act_sel    = act_q[i];
                fright_sel = fright_q[i];
            end
        end
    end

    always_comb begin
        // Zero-extended before subtracting so distant coordinates never wrap into range
        dx         = $signed({1'b0, px_q}) - $signed({1'b0, gx_sel});
        dy         = $signed({1'b0, py_q}) - $signed({1'b0, gy_sel});
        adx        = dx[11] ? 12'(-dx) : 12'(dx);
        ady        = dy[10] ? 11'(-dy) : 11'(dy);
        tile_match = ((px_q >> TILE_SHIFT) == (gx_sel >> TILE_SHIFT)) &&
                     ((py_q >> TILE_SHIFT) == (gy_sel >> TILE_SHIFT));
        box_match  = (adx < 12'(HIT_DIST)) && (ady < 11'(HIT_DIST));
        contact    = act_sel && ((HIT_MODE == 0) ? tile_match : box_match);
    end

    assign grace_active = (grace_q != 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            px_q        <= '0;
            py_q        <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            act_q       <= '0;
            fright_q    <= '0;
            lethal_q    <= 1'b0;
            eaten_q     <= '0;
            grace_q     <= '0;
            busy        <= 1'b0;
            pacman_hit  <= 1'b0;
            ghost_eaten <= '0;
            lives       <= 4'(LIVES_INIT);
            game_over   <= 1'b0;
        end else begin
            pacman_hit  <= 1'b0;
            ghost_eaten <= '0;
            if (game_restart) begin
                state_q   <= StIdle;
                idx_q     <= '0;
                lethal_q  <= 1'b0;
                eaten_q   <= '0;
                grace_q   <= '0;
                busy      <= 1'b0;
                lives     <= 4'(LIVES_INIT);
                game_over <= 1'b0;
            end else begin
                // Frame countdown runs in every state; a REPORT load below overrides it
                if (frame_tick && grace_q != 8'd0) begin
                    grace_q <= grace_q - 8'd1;
                end
                unique case (state_q)
                    StIdle: begin
                        if (frame_tick && !game_over) begin
                            px_q     <= pacman_x;
                            py_q     <= pacman_y;
                            gx_q     <= ghost_x;
                            gy_q     <= ghost_y;
                            act_q    <= ghost_active;
                            fright_q <= ghost_frightened;
                            lethal_q <= 1'b0;
                            eaten_q  <= '0;
                            idx_q    <= '0;
                            busy     <= 1'b1;
                            state_q  <= StScan;
                        end
                    end
                    StScan: begin
                        if (contact) begin
                            if (fright_sel) begin
                                eaten_q[idx_q] <= 1'b1;
                            end else begin
                                lethal_q <= 1'b1;
                            end
                        end
                        if (idx_q == LastIdx) begin
                            state_q <= StReport;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    StReport: begin
                        ghost_eaten <= eaten_q;
                        if (lethal_q && grace_q == 8'd0) begin
                            pacman_hit <= 1'b1;
                            lives      <= lives - 4'd1;
                            if (lives == 4'd1) begin
                                game_over <= 1'b1;
                            end else begin
                                grace_q <= 8'(GRACE_FRAMES);
                            end
                        end
                        idx_q   <= '0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ghost_collision_monitor.sv
module tb_ghost_collision_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        game_restart = 1'b0;
    logic [10:0] pacman_x = '0;
    logic [9:0]  pacman_y = '0;
    logic [43:0] ghost_x = '0;
    logic [39:0] ghost_y = '0;
    logic [3:0]  ghost_active = '0;
    logic [3:0]  ghost_frightened = '0;

    logic       busy0, hit0, grace0, over0;
    logic [3:0] eaten0, lives0;
    logic       busy1, hit1, grace1, over1;
    logic [3:0] eaten1, lives1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ghost_collision_monitor #(
        .NUM_GHOSTS(4), .TILE_SHIFT(4), .HIT_MODE(0), .HIT_DIST(8),
        .LIVES_INIT(3), .GRACE_FRAMES(2)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_restart(game_restart),
        .pacman_x(pacman_x), .pacman_y(pacman_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .ghost_active(ghost_active), .ghost_frightened(ghost_frightened),
        .busy(busy0), .pacman_hit(hit0), .ghost_eaten(eaten0), .lives(lives0),
        .grace_active(grace0), .game_over(over0)
    );

    ghost_collision_monitor #(
        .NUM_GHOSTS(4), .TILE_SHIFT(4), .HIT_MODE(1), .HIT_DIST(8),
        .LIVES_INIT(3), .GRACE_FRAMES(60)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_restart(game_restart),
        .pacman_x(pacman_x), .pacman_y(pacman_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .ghost_active(ghost_active), .ghost_frightened(ghost_frightened),
        .busy(busy1), .pacman_hit(hit1), .ghost_eaten(eaten1), .lives(lives1),
        .grace_active(grace1), .game_over(over1)
    );

    typedef struct packed {
        logic [10:0] px;
        logic [9:0]  py;
        logic [43:0] gx;
        logic [39:0] gy;
        logic [3:0]  act;
        logic [3:0]  fr;
        logic        h0;
        logic [3:0]  e0;
        logic        h1;
        logic [3:0]  e1;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int i);
        pacman_x         = vecs[i].px;
        pacman_y         = vecs[i].py;
        ghost_x          = vecs[i].gx;
        ghost_y          = vecs[i].gy;
        ghost_active     = vecs[i].act;
        ghost_frightened = vecs[i].fr;
    endtask

    task automatic restart();
        @(negedge clk) game_restart = 1'b1;
        @(negedge clk) game_restart = 1'b0;
    endtask

    // Tick at edge 0, capture busy after edge 4 and the report after edge 5
    task automatic run_frame(output logic h0, output logic [3:0] e0, output logic h1,
                             output logic [3:0] e1, output logic b);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1 b = busy0;
        @(posedge clk);
        #1;
        h0 = hit0;
        e0 = eaten0;
        h1 = hit1;
        e1 = eaten1;
    endtask

    logic       rh0, rh1, rb;
    logic [3:0] re0, re1;
    int         pulses;

    initial begin
        vecs[0] = '{px: 11'd100, py: 10'd50,
                    gx: {11'd0, 11'd110, 11'd0, 11'd0}, gy: {10'd0, 10'd60, 10'd0, 10'd0},
                    act: 4'b0100, fr: 4'b0000, h0: 1'b1, e0: 4'b0000, h1: 1'b0, e1: 4'b0000};
        vecs[1] = '{px: 11'd100, py: 10'd50,
                    gx: {11'd0, 11'd110, 11'd0, 11'd96}, gy: {10'd0, 10'd60, 10'd0, 10'd48},
                    act: 4'b0101, fr: 4'b0100, h0: 1'b1, e0: 4'b0100, h1: 1'b1, e1: 4'b0000};
        vecs[2] = '{px: 11'd500, py: 10'd300,
                    gx: {11'd0, 11'd0, 11'd507, 11'd0}, gy: {10'd0, 10'd0, 10'd300, 10'd0},
                    act: 4'b0010, fr: 4'b0000, h0: 1'b1, e0: 4'b0000, h1: 1'b1, e1: 4'b0000};
        vecs[3] = '{px: 11'd500, py: 10'd300,
                    gx: {11'd0, 11'd0, 11'd508, 11'd0}, gy: {10'd0, 10'd0, 10'd300, 10'd0},
                    act: 4'b0010, fr: 4'b0000, h0: 1'b1, e0: 4'b0000, h1: 1'b0, e1: 4'b0000};
        vecs[4] = '{px: 11'd3, py: 10'd100,
                    gx: {11'd2045, 11'd0, 11'd0, 11'd0}, gy: {10'd100, 10'd0, 10'd0, 10'd0},
                    act: 4'b1000, fr: 4'b0000, h0: 1'b0, e0: 4'b0000, h1: 1'b0, e1: 4'b0000};
        vecs[5] = '{px: 11'd200, py: 10'd200,
                    gx: {11'd0, 11'd0, 11'd0, 11'd200}, gy: {10'd0, 10'd0, 10'd0, 10'd200},
                    act: 4'b0000, fr: 4'b0000, h0: 1'b0, e0: 4'b0000, h1: 1'b0, e1: 4'b0000};
        vecs[6] = '{px: 11'd500, py: 10'd300,
                    gx: {11'd500, 11'd0, 11'd0, 11'd0}, gy: {10'd293, 10'd0, 10'd0, 10'd0},
                    act: 4'b1000, fr: 4'b1000, h0: 1'b0, e0: 4'b1000, h1: 1'b0, e1: 4'b1000};
        vecs[7] = '{px: 11'd508, py: 10'd300,
                    gx: {11'd0, 11'd0, 11'd0, 11'd500}, gy: {10'd0, 10'd0, 10'd0, 10'd300},
                    act: 4'b0001, fr: 4'b0001, h0: 1'b0, e0: 4'b0001, h1: 1'b0, e1: 4'b0000};

        // Reset values
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_hit", 32'(hit0), 32'd0);
        check("rst_eaten", 32'(eaten0), 32'd0);
        check("rst_lives", 32'(lives0), 32'd3);
        check("rst_grace", 32'(grace0), 32'd0);
        check("rst_over", 32'(over0), 32'd0);
        check("rst_lives_m1", 32'(lives1), 32'd3);

        // Table: every vector starts from a fresh restart on both modes
        for (int i = 0; i < 8; i++) begin
            restart();
            apply_vec(i);
            run_frame(rh0, re0, rh1, re1, rb);
            check($sformatf("v%0d_busy", i), 32'(rb), 32'd1);
            check($sformatf("v%0d_busy_done", i), 32'(busy0), 32'd0);
            check($sformatf("v%0d_hit_m0", i), 32'(rh0), 32'(vecs[i].h0));
            check($sformatf("v%0d_eaten_m0", i), 32'(re0), 32'(vecs[i].e0));
            check($sformatf("v%0d_hit_m1", i), 32'(rh1), 32'(vecs[i].h1));
            check($sformatf("v%0d_eaten_m1", i), 32'(re1), 32'(vecs[i].e1));
            check($sformatf("v%0d_lives_m0", i), 32'(lives0), vecs[i].h0 ? 32'd2 : 32'd3);
            check($sformatf("v%0d_lives_m1", i), 32'(lives1), vecs[i].h1 ? 32'd2 : 32'd3);
            check($sformatf("v%0d_grace_m0", i), 32'(grace0), 32'(vecs[i].h0));
            @(posedge clk);
            #1 check($sformatf("v%0d_pulse_end", i), 32'({hit0, eaten0}), 32'd0);
        end

        // Grace window and game over (mode 0, GRACE_FRAMES=2)
        restart();
        apply_vec(1);
        run_frame(rh0, re0, rh1, re1, rb);
        check("g1_hit", 32'(rh0), 32'd1);
        check("g1_eaten", 32'(re0), 32'b0100);
        check("g1_lives", 32'(lives0), 32'd2);
        run_frame(rh0, re0, rh1, re1, rb);
        check("g2_hit_discard", 32'(rh0), 32'd0);
        check("g2_eaten", 32'(re0), 32'b0100);
        check("g2_lives", 32'(lives0), 32'd2);
        check("g2_grace", 32'(grace0), 32'd1);
        ghost_active = 4'b0000;
        run_frame(rh0, re0, rh1, re1, rb);
        check("g3_grace_clear", 32'(grace0), 32'd0);
        apply_vec(1);
        run_frame(rh0, re0, rh1, re1, rb);
        check("g4_hit", 32'(rh0), 32'd1);
        check("g4_lives", 32'(lives0), 32'd1);
        ghost_active = 4'b0000;
        run_frame(rh0, re0, rh1, re1, rb);
        run_frame(rh0, re0, rh1, re1, rb);
        check("g5_grace_clear", 32'(grace0), 32'd0);
        apply_vec(1);
        run_frame(rh0, re0, rh1, re1, rb);
        check("g6_hit", 32'(rh0), 32'd1);
        check("g6_lives", 32'(lives0), 32'd0);
        check("g6_over", 32'(over0), 32'd1);
        check("g6_grace_noload", 32'(grace0), 32'd0);
        run_frame(rh0, re0, rh1, re1, rb);
        check("g7_busy_over", 32'(rb), 32'd0);
        check("g7_hit_over", 32'(rh0), 32'd0);
        check("g7_lives_over", 32'(lives0), 32'd0);
        restart();
        #1;
        check("g8_restart_lives", 32'(lives0), 32'd3);
        check("g8_restart_over", 32'(over0), 32'd0);

        // Second tick during the scan is ignored: exactly one report
        restart();
        apply_vec(0);
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk) frame_tick = (c == 0 || c == 2);
            @(posedge clk);
            #1 if (hit0) pulses++;
        end
        frame_tick = 1'b0;
        check("dbl_tick_reports", 32'(pulses), 32'd1);
        check("dbl_tick_lives", 32'(lives0), 32'd2);

        // Restart mid-scan: lives restored, no pulses, idle
        apply_vec(1);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            frame_tick   = (c == 0);
            game_restart = (c == 3);
            @(posedge clk);
            #1;
            if (hit0 || eaten0 != 4'd0) pulses++;
            if (c == 3) begin
                check("rs_busy", 32'(busy0), 32'd0);
                check("rs_lives", 32'(lives0), 32'd3);
                check("rs_grace", 32'(grace0), 32'd0);
            end
        end
        game_restart = 1'b0;
        frame_tick   = 1'b0;
        check("rs_pulses", 32'(pulses), 32'd0);

        // Asynchronous reset mid-scan
        restart();
        apply_vec(0);
        run_frame(rh0, re0, rh1, re1, rb);
        check("ar_pre_lives", 32'(lives0), 32'd2);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy0), 32'd0);
        check("ar_lives", 32'(lives0), 32'd3);
        check("ar_grace", 32'(grace0), 32'd0);
        check("ar_outs", 32'({hit0, eaten0, over0}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1 if (hit0 || eaten0 != 4'd0 || busy0) pulses++;
        end
        check("ar_quiet", 32'(pulses), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ghost_collision_monitor.md
# ghost_collision_monitor

Parametrised, frame-synchronous successor to the single-ghost collision check. On each frame tick it snapshots Pac-Man and up to NUM_GHOSTS ghost positions, scans the ghosts sequentially (one per clock), and classifies each contact as lethal or as a ghost eaten (frightened ghost). It owns the lives counter, a post-death grace window and the game-over flag. It sits between the sprite position registers and the game control FSM.

## Interface
- NUM_GHOSTS, 4: ghosts scanned per frame (1..8).
- TILE_SHIFT, 4: log2 tile size in pixels; used when HIT_MODE=0.
- HIT_MODE, 0: 0 = same-tile match; 1 = pixel box overlap.
- HIT_DIST, 8: box half-width in pixels for HIT_MODE=1 (1..255).
- LIVES_INIT, 3: lives after reset/restart (1..15).
- GRACE_FRAMES, 60: frames of invulnerability after a lethal hit (0..255).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- frame_tick  in  1  one-cycle start-of-frame strobe.
- game_restart  in  1  synchronous restart request.
- pacman_x  in  11  Pac-Man display x.
- pacman_y  in  10  Pac-Man display y.
- ghost_x  in  NUM_GHOSTS*11  packed ghost x; ghost i at [i*11 +: 11].
- ghost_y  in  NUM_GHOSTS*10  packed ghost y; ghost i at [i*10 +: 10].
- ghost_active  in  NUM_GHOSTS  ghost i participates.
- ghost_frightened  in  NUM_GHOSTS  ghost i is edible.
- busy  out  1  scan in progress.
- pacman_hit  out  1  one-cycle pulse: lethal collision accepted.
- ghost_eaten  out  NUM_GHOSTS  one-cycle pulse mask of eaten ghosts.
- lives  out  4  remaining lives.
- grace_active  out  1  invulnerability window running.
- game_over  out  1  level; lives exhausted.

## Operation
- States: IDLE, SCAN, REPORT.
- IDLE: frame_tick accepted only when game_over=0; the accepting edge snapshots all position, active and frightened inputs into registers, clears the hit accumulators, sets idx=0, and moves to SCAN. Inputs may change freely after that edge.
- SCAN: each cycle compares snapshot ghost idx against the Pac-Man snapshot. Contact is defined as:
  - HIT_MODE=0: (px>>TILE_SHIFT)==(gx>>TILE_SHIFT) and (py>>TILE_SHIFT)==(gy>>TILE_SHIFT).
  - HIT_MODE=1: |px-gx|<HIT_DIST and |py-gy|<HIT_DIST. Differences are taken at 12 bits signed (x) and 11 bits signed (y), with no wrap.
- Classification of a contact:
  - Inactive ghosts never make contact.
  - Contact with a frightened ghost sets eaten[idx].
  - Contact with a non-frightened ghost sets the lethal flag.
  - At idx=NUM_GHOSTS-1 the FSM moves to REPORT.
- REPORT (single cycle), then IDLE:
  - ghost_eaten is driven with eaten[].
  - If lethal=1 and grace_active=0: pacman_hit=1 and lives decrements.
    - If the new lives value is 0: game_over=1 and the grace counter is not loaded.
    - Otherwise the grace counter loads GRACE_FRAMES.
  - If lethal=1 and grace_active=1: the hit is discarded. Eating is still reported.
  - Lethal and eaten contacts in the same frame are both reported.
- Grace counter (8-bit):
  - Decrements on every frame_tick while nonzero, in any state.
  - A load on the same edge as a decrement takes priority.
  - grace_active = (counter != 0).
- frame_tick while busy=1 is ignored for scanning and is not queued.
- game_restart (any state) has priority over all else:
  - lives=LIVES_INIT, game_over=0, grace counter=0.
  - FSM goes to IDLE and pending results are discarded.
  - No pulses are issued that cycle.
- Reset values: busy=0, pacman_hit=0, ghost_eaten=0, lives=LIVES_INIT, grace_active=0, game_over=0. FSM=IDLE, idx=0, all snapshots cleared.

## Timing
- Edge 0: frame_tick sampled in IDLE; the snapshot is taken.
- Edges 1..N (N=NUM_GHOSTS): ghost 0..N-1 compared.
- Edge N+1: REPORT registers pulses and updates lives, game_over and grace. pacman_hit and ghost_eaten are high for exactly the cycle between edges N+1 and N+2.
- busy is high from edge 0 to edge N+1.
- Minimum frame_tick spacing for every frame to be scanned: N+2 cycles.
- Reset asserted mid-scan aborts immediately with no pulses. After deassertion the block waits for the next frame_tick.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- N=4, mode 0, TILE_SHIFT=4: pacman (100,50), ghost2 (110,60) active, not frightened. Tick at edge 0 → pacman_hit pulse after edge 5, lives 3→2, grace_active=1, ghost_eaten=0.
- Same positions with ghost2 frightened and ghost0 on the same tile, not frightened → ghost_eaten=4'b0100 and pacman_hit in the same cycle. Repeat during grace → ghost_eaten only, lives unchanged.
- GRACE_FRAMES=2: after a hit, 2 ticks clear grace_active. A contact on the 3rd tick kills; three kills from LIVES_INIT=3 → lives=0, game_over=1, and later ticks leave busy=0.
- Mode 1, HIT_DIST=8: dx=7 → hit; dx=8 → no hit; pacman_x=3, ghost_x=2045 → no hit (no wrap). An inactive ghost on top of pacman → no hit.
- Tick at edge 0, second tick at edge 2 → ignored, exactly one REPORT. game_restart at edge 3 → no pulses, lives=LIVES_INIT, busy=0 at edge 4.
- rst_n low during SCAN → all outputs at reset values asynchronously, lives=LIVES_INIT.
